// File: rtl/fpga_ram_pkg.sv
// Shared constants for FPGA RAM instances and the requester-index encoding
// used by the two-port RAM arbiter.
package fpga_ram_pkg;

    localparam int FPGA_RAM_DATAWIDTH = 32;
    localparam int FPGA_RAM_ADDRWIDTH = 10;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_e;

endpackage : fpga_ram_pkg

// File: rtl/fpga_ram_arb_if.sv
// Request/response bundle between the two requesters and fpga_ram_arb.
// The master side is the requester pair; the slave side is the arbiter.
interface fpga_ram_arb_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 10
) ();

    logic                 Req0Valid;
    logic                 Req0Ready;
    logic                 Req0Write;
    logic [ADDRWIDTH-1:0] Req0Addr;
    logic [DATAWIDTH-1:0] Req0WData;
    logic                 Rsp0Valid;
    logic [DATAWIDTH-1:0] Rsp0RData;

    logic                 Req1Valid;
    logic                 Req1Ready;
    logic                 Req1Write;
    logic [ADDRWIDTH-1:0] Req1Addr;
    logic [DATAWIDTH-1:0] Req1WData;
    logic                 Rsp1Valid;
    logic [DATAWIDTH-1:0] Rsp1RData;

    modport master (
        output Req0Valid, Req0Write, Req0Addr, Req0WData,
        input  Req0Ready, Rsp0Valid, Rsp0RData,
        output Req1Valid, Req1Write, Req1Addr, Req1WData,
        input  Req1Ready, Rsp1Valid, Rsp1RData
    );

    modport slave (
        input  Req0Valid, Req0Write, Req0Addr, Req0WData,
        output Req0Ready, Rsp0Valid, Rsp0RData,
        input  Req1Valid, Req1Write, Req1Addr, Req1WData,
        output Req1Ready, Rsp1Valid, Rsp1RData
    );

endinterface : fpga_ram_arb_if

// File: rtl/fpga_ram.sv
// Single-port synchronous RAM, registered read, write-first output.
// Contents are never reset.
module fpga_ram #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 10
) (
    input  logic                 PortAClk,
    input  logic                 PortAEn,
    input  logic                 PortAWe,
    input  logic [ADDRWIDTH-1:0] PortAAddr,
    input  logic [DATAWIDTH-1:0] PortAWData,
    output logic [DATAWIDTH-1:0] PortARData
);

    logic [DATAWIDTH-1:0] mem_r [0:(2**ADDRWIDTH)-1];
    logic [DATAWIDTH-1:0] rdata_r;

    // Memory array and write-first read register.
    always_ff @(posedge PortAClk) begin
        if (PortAEn) begin
            if (PortAWe) begin
                mem_r[PortAAddr] <= PortAWData;
                rdata_r          <= PortAWData;
            end else begin
                rdata_r <= mem_r[PortAAddr];
            end
        end
    end

    assign PortARData = rdata_r;

endmodule : fpga_ram

// File: rtl/fpga_ram_arb.sv
// Round-robin arbiter giving two requesters one access per cycle to a shared
// single-port RAM and steering each read result back to its issuer.
module fpga_ram_arb
    import fpga_ram_pkg::*;
#(
    parameter int DATAWIDTH = FPGA_RAM_DATAWIDTH,
    parameter int ADDRWIDTH = FPGA_RAM_ADDRWIDTH
) (
    input  logic           Clk,
    input  logic           RstB,
    fpga_ram_arb_if.slave  bus
);

    logic                 grant_valid_s;
    req_idx_e             grant_idx_s;
    logic                 ram_we_s;
    logic [ADDRWIDTH-1:0] ram_addr_s;
    logic [DATAWIDTH-1:0] ram_wdata_s;
    logic [DATAWIDTH-1:0] ram_rdata_s;

    req_idx_e             last_grant_r;
    logic                 pend_valid_r;
    req_idx_e             pend_idx_r;
    logic [DATAWIDTH-1:0] hold0_r;
    logic [DATAWIDTH-1:0] hold1_r;

    logic                 rsp0_valid_s;
    logic                 rsp1_valid_s;
    logic [DATAWIDTH-1:0] rsp0_rdata_s;
    logic [DATAWIDTH-1:0] rsp1_rdata_s;

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = REQ0;
        if (RstB) begin
            case ({bus.Req1Valid, bus.Req0Valid})
                2'b01: begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = REQ0;
                end
                2'b10: begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = REQ1;
                end
                2'b11: begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = (last_grant_r == REQ1) ? REQ0 : REQ1;
                end
                default: begin
                    grant_valid_s = 1'b0;
                    grant_idx_s   = REQ0;
                end
            endcase
        end else begin
            grant_valid_s = 1'b0;
            grant_idx_s   = REQ0;
        end
    end

    // RAM port mux from the granted requester.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = bus.Req0Addr;
        ram_wdata_s = bus.Req0WData;
        if (grant_idx_s == REQ1) begin
            ram_we_s    = grant_valid_s & bus.Req1Write;
            ram_addr_s  = bus.Req1Addr;
            ram_wdata_s = bus.Req1WData;
        end else begin
            ram_we_s    = grant_valid_s & bus.Req0Write;
            ram_addr_s  = bus.Req0Addr;
            ram_wdata_s = bus.Req0WData;
        end
    end

    fpga_ram #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH)
    ) u_ram (
        .PortAClk   (Clk),
        .PortAEn    (grant_valid_s),
        .PortAWe    (ram_we_s),
        .PortAAddr  (ram_addr_s),
        .PortAWData (ram_wdata_s),
        .PortARData (ram_rdata_s)
    );

    // LastGrant and pending-read tracking; a reset drops any in-flight read.
    always_ff @(posedge Clk or negedge RstB) begin
        if (!RstB) begin
            last_grant_r <= REQ1;
            pend_valid_r <= 1'b0;
            pend_idx_r   <= REQ0;
        end else if (grant_valid_s) begin
            last_grant_r <= grant_idx_s;
            pend_valid_r <= ~ram_we_s;
            pend_idx_r   <= grant_idx_s;
        end else begin
            pend_valid_r <= 1'b0;
        end
    end

    // Last delivered read data per requester, shown while no response is due.
    always_ff @(posedge Clk or negedge RstB) begin
        if (!RstB) begin
            hold0_r <= {DATAWIDTH{1'b0}};
            hold1_r <= {DATAWIDTH{1'b0}};
        end else begin
            if (rsp0_valid_s) hold0_r <= ram_rdata_s;
            if (rsp1_valid_s) hold1_r <= ram_rdata_s;
        end
    end

    // Response demux: the RAM register is read directly on the delivery cycle.
    always_comb begin
        rsp0_valid_s = pend_valid_r & (pend_idx_r == REQ0);
        rsp1_valid_s = pend_valid_r & (pend_idx_r == REQ1);
        if (rsp0_valid_s) rsp0_rdata_s = ram_rdata_s;
        else              rsp0_rdata_s = hold0_r;
        if (rsp1_valid_s) rsp1_rdata_s = ram_rdata_s;
        else              rsp1_rdata_s = hold1_r;
    end

    assign bus.Req0Ready = grant_valid_s & (grant_idx_s == REQ0);
    assign bus.Req1Ready = grant_valid_s & (grant_idx_s == REQ1);
    assign bus.Rsp0Valid = rsp0_valid_s;
    assign bus.Rsp1Valid = rsp1_valid_s;
    assign bus.Rsp0RData = rsp0_rdata_s;
    assign bus.Rsp1RData = rsp1_rdata_s;

endmodule : fpga_ram_arb

// File: doc/fpga_ram_arb.md
Name: fpga_ram_arb

Overview:
Two-requester round-robin arbiter that shares one single-port synchronous FPGA RAM (1-cycle registered read, write-first output).
- Accepts valid/ready read and write requests from two masters.
- Drives exactly one RAM access per cycle.
- Routes each read datum back to the requester that issued it, one cycle after the grant.
- Sits between the boot/debug loader (requester 1) and the on-chip scratch/ROM-replacement path (requester 0) in FPGA builds.

Parameters:
DATAWIDTH, 32, RAM word width in bits
ADDRWIDTH, 10, RAM address width; depth = 2**ADDRWIDTH words

Ports:
Clk  input  1  single clock for arbiter and RAM
RstB  input  1  asynchronous, active-low reset
Req0Valid  input  1  requester 0 request valid
Req0Ready  output  1  requester 0 request accepted this cycle
Req0Write  input  1  1 = write, 0 = read
Req0Addr  input  ADDRWIDTH  word address
Req0WData  input  DATAWIDTH  write data
Rsp0Valid  output  1  read data valid for requester 0 (single-cycle pulse)
Rsp0RData  output  DATAWIDTH  read data
Req1Valid / Req1Ready / Req1Write / Req1Addr / Req1WData / Rsp1Valid / Rsp1RData  same as requester 0, for requester 1

Behaviour:
- Interface fixed: one clock, Clk; reset RstB is asynchronous, active-low.
- Reset values:
  - Req0Ready = Req1Ready = 0 while RstB is low.
  - Rsp0Valid = Rsp1Valid = 0.
  - Rsp*RData = 0.
  - LastGrant = 1, so requester 0 wins the first tie.
  - Pending-read register cleared.
- Arbitration is combinational each cycle:
  - Only one ReqNValid high: grant N.
  - Both high: grant the requester not equal to LastGrant.
  - Neither high: no grant; RAM WriteEnable = 0; LastGrant holds.
- ReqNReady = grant to N. The handshake completes when ReqNValid and ReqNReady are both high in the same cycle. Ready is never asserted without Valid.
- On a grant cycle:
  - RAM address, data and write-enable come from the granted requester.
  - LastGrant <= granted index at the next edge.
- Write: the RAM updates at the grant edge. There is no response. The RAM's write-through output is ignored and never produces RspValid.
- Read:
  - At the grant edge, record the pending-read valid bit and the requester index.
  - In the following cycle (latency 1 from the handshake), RspNValid = 1 for exactly one cycle for the recorded requester.
  - RspNRData = RAM output in that cycle.
  - The other requester's Rsp*Valid stays 0.
- Rsp*RData holds its last delivered value when Valid is 0; a registered mux updated only on delivery.
- There is no response backpressure. Requesters must sink RspValid unconditionally.
- Back-to-back reads from the same requester sustain one per cycle. Alternating requesters under continuous contention sustain one per cycle at 50/50 share.
- Read-after-write to the same address on consecutive grants returns the new data. The RAM is write-first; no bypass is needed in the arbiter.
- Same address from both requesters in the same cycle: only the granted access occurs. The loser retries later because its Valid stays high, so it observes the winner's write.
- Requesters must hold Valid, Write, Addr and WData stable until Ready. Inputs may change freely after the handshake.
- Reset asserted mid-operation:
  - A pending read response is dropped; no RspValid after reset release.
  - LastGrant returns to 1.
  - RAM contents are not cleared.
- Address wrap: the address is used modulo depth; no range check.

Decomposition:
- Shared package (fpga_ram_pkg): requester-index encoding (REQ0 = 0, REQ1 = 1), and the default DATAWIDTH/ADDRWIDTH constants used by FPGA top-level RAM instances.
- One sub-module: the existing single-port fpga_ram, instantiated once with the passed-through DATAWIDTH/ADDRWIDTH.
- The arbiter logic stays flat: grant mux, LastGrant flop, pending-read flops, response demux.

Test Plan:
- Reset then idle: RstB low 3 cycles, then high → all Ready/RspValid are 0; no RAM write occurs (read back at address 0 returns its preload).
- Single writer/reader: requester 0 writes 0xDEADBEEF at address 0x005, then reads 0x005 → Req0Ready high on both cycles; Rsp0Valid pulses one cycle after the read with 0xDEADBEEF; Rsp1Valid stays 0.
- Contention: both requesters hold read Valid for 4 cycles after reset → grants go 0,1,0,1; Rsp0Valid/Rsp1Valid alternate, each carrying its own address's data with 1-cycle latency.
- Same-address race: requester 0 writes 0x11 to 0x3FF while requester 1 reads 0x3FF in the same cycle (LastGrant = 1) → requester 0 granted first; requester 1 granted next cycle and returns 0x11.
- Write no-response: requester 1 writes 0xA5A5A5A5 to 0x010 → no Rsp1Valid; a subsequent requester 0 read of 0x010 returns 0xA5A5A5A5.
- Reset mid-read: requester 1 read handshakes, RstB asserted before the next edge → Rsp1Valid never pulses; after release, requester 0 wins the first tie.
